// File: rtl/game_dumper.sv
// game_dumper: reads a loaded game back out of SDRAM and streams it as an
// iNES file (16-byte header, then PRG from address 0, then CHR from CHR_BASE).
//
// Ports:
//   clk, reset_n        system clock, asynchronous active-low reset
//   start               one-cycle pulse, begins a dump (ignored unless idle)
//   mapper_flags        active mapper flags, latched on start
//   invert_mirroring    OSD mirroring invert, latched on start
//   mem_addr/mem_read   SDRAM byte address and one-cycle read request
//   mem_data/mem_ack    SDRAM read data and its valid strobe
//   out_data/out_valid  stream byte and valid, accepted when out_ready
//   busy/done/error     dump status; done and error are sticky until start
module game_dumper #(
   parameter logic [21:0] CHR_BASE    = 22'h200000,
   parameter int unsigned ACK_TIMEOUT = 1023
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        start,
   input  logic [31:0] mapper_flags,
   input  logic        invert_mirroring,
   output logic [21:0] mem_addr,
   output logic        mem_read,
   input  logic [7:0]  mem_data,
   input  logic        mem_ack,
   output logic [7:0]  out_data,
   output logic        out_valid,
   input  logic        out_ready,
   output logic        busy,
   output logic        done,
   output logic        error
);

   localparam int unsigned AW = 22;
   localparam int unsigned RW = 23;
   localparam int unsigned TW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
   localparam logic [RW-1:0] PRG_UNIT = RW'(16384);
   localparam logic [RW-1:0] CHR_UNIT = RW'(8192);

   typedef struct packed {
      logic       four_screen;
      logic       has_chr_ram;
      logic       mirroring;
      logic [2:0] chr_size;
      logic [2:0] prg_size;
      logic [7:0] mapper;
   } flags_t;

   typedef enum logic [2:0] {
      S_IDLE,
      S_HEADER,
      S_REQ,
      S_WAIT,
      S_SEND,
      S_FINISH,
      S_FAIL
   } state_t;

   state_t          state, state_n;
   logic [3:0]      hidx, hidx_n;
   flags_t          flags_q, flags_n;
   logic            inv_q, inv_n;
   logic            region_q, region_n;   // 0 = PRG, 1 = CHR
   logic [RW-1:0]   rem_q, rem_n, rem_dec;
   logic [TW-1:0]   tcnt_q, tcnt_n;
   logic [AW-1:0]   addr_n;
   logic            read_n;
   logic [7:0]      odata_n;
   logic            ovalid_n;
   logic            busy_n, done_n, error_n;

   // Bits above four_screen carry no meaning for the dump.
   logic unused_flags;
   assign unused_flags = ^mapper_flags[31:17];

   // iNES header byte for a given index, rebuilt from the latched flags.
   function automatic logic [7:0] hdr_byte(input logic [3:0] idx,
                                           input flags_t f,
                                           input logic inv);
      logic [7:0] b;
      case (idx)
         4'd0:    b = 8'h4E;
         4'd1:    b = 8'h45;
         4'd2:    b = 8'h53;
         4'd3:    b = 8'h1A;
         4'd4:    b = 8'd1 << f.prg_size;
         4'd5:    b = f.has_chr_ram ? 8'h00 : (8'd1 << f.chr_size);
         4'd6:    b = {f.mapper[3:0], f.four_screen, 2'b00, f.mirroring ^ inv};
         4'd7:    b = {f.mapper[7:4], 4'b0000};
         default: b = 8'h00;
      endcase
      return b;
   endfunction

   // State and registered outputs.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state     <= S_IDLE;
         hidx      <= '0;
         flags_q   <= '0;
         inv_q     <= 1'b0;
         region_q  <= 1'b0;
         rem_q     <= '0;
         tcnt_q    <= '0;
         mem_addr  <= '0;
         mem_read  <= 1'b0;
         out_data  <= '0;
         out_valid <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         error     <= 1'b0;
      end else begin
         state     <= state_n;
         hidx      <= hidx_n;
         flags_q   <= flags_n;
         inv_q     <= inv_n;
         region_q  <= region_n;
         rem_q     <= rem_n;
         tcnt_q    <= tcnt_n;
         mem_addr  <= addr_n;
         mem_read  <= read_n;
         out_data  <= odata_n;
         out_valid <= ovalid_n;
         busy      <= busy_n;
         done      <= done_n;
         error     <= error_n;
      end
   end

   // Next-state and next-output logic; mem_read is high only while in REQ.
   always_comb begin
      state_n  = state;
      hidx_n   = hidx;
      flags_n  = flags_q;
      inv_n    = inv_q;
      region_n = region_q;
      rem_n    = rem_q;
      tcnt_n   = tcnt_q;
      addr_n   = mem_addr;
      read_n   = 1'b0;
      odata_n  = out_data;
      ovalid_n = out_valid;
      busy_n   = busy;
      done_n   = done;
      error_n  = error;
      rem_dec  = rem_q - RW'(1);

      case (state)
         S_IDLE: begin
            if (start) begin
               flags_n  = flags_t'(mapper_flags[16:0]);
               inv_n    = invert_mirroring;
               done_n   = 1'b0;
               error_n  = 1'b0;
               busy_n   = 1'b1;
               hidx_n   = '0;
               odata_n  = 8'h4E;
               ovalid_n = 1'b1;
               state_n  = S_HEADER;
            end
         end

         S_HEADER: begin
            if (out_ready) begin
               if (hidx == 4'd15) begin
                  ovalid_n = 1'b0;
                  region_n = 1'b0;
                  addr_n   = '0;
                  rem_n    = PRG_UNIT << flags_q.prg_size;
                  read_n   = 1'b1;
                  state_n  = S_REQ;
               end else begin
                  hidx_n  = hidx + 4'd1;
                  odata_n = hdr_byte(hidx + 4'd1, flags_q, inv_q);
               end
            end
         end

         S_REQ: begin
            tcnt_n  = '0;
            state_n = S_WAIT;
         end

         // An ack on the final timeout cycle still counts as data.
         S_WAIT: begin
            if (mem_ack) begin
               odata_n  = mem_data;
               ovalid_n = 1'b1;
               state_n  = S_SEND;
            end else if (tcnt_q == TW'(ACK_TIMEOUT - 1)) begin
               ovalid_n = 1'b0;
               error_n  = 1'b1;
               done_n   = 1'b1;
               busy_n   = 1'b0;
               state_n  = S_FAIL;
            end else begin
               tcnt_n = tcnt_q + TW'(1);
            end
         end

         S_SEND: begin
            if (out_ready) begin
               ovalid_n = 1'b0;
               addr_n   = mem_addr + AW'(1);
               rem_n    = rem_dec;
               if (rem_dec != '0) begin
                  read_n  = 1'b1;
                  state_n = S_REQ;
               end else if (!region_q && !flags_q.has_chr_ram) begin
                  region_n = 1'b1;
                  addr_n   = CHR_BASE;
                  rem_n    = CHR_UNIT << flags_q.chr_size;
                  read_n   = 1'b1;
                  state_n  = S_REQ;
               end else begin
                  done_n  = 1'b1;
                  busy_n  = 1'b0;
                  state_n = S_FINISH;
               end
            end
         end

         S_FINISH: state_n = S_IDLE;
         S_FAIL:   state_n = S_IDLE;
         default:  state_n = S_IDLE;
      endcase
   end

endmodule
